packet_checker: RTL and testbench
=================================

PACKET_CHECKER -- requirements
Module: packet_checker

Interface
REQ-001 Parameter: EXP_WORDS, default 31, valid data words expected per packet before the done pulse.
REQ-002 Parameter: CNT_W, default 16, width of every statistics counter.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  32  received packet word.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_done  input  1  single-cycle end-of-packet pulse.
REQ-008 clr_stats  input  1  synchronous clear of all counters.
REQ-009 busy  output  1  high while in RUN state.
REQ-010 pkt_ok  output  1  one-cycle pulse: packet passed.
REQ-011 pkt_bad  output  1  one-cycle pulse: packet failed.
REQ-012 pkt_count  output  CNT_W  packets completed (ok or bad).
REQ-013 word_err_count  output  CNT_W  mismatching data words.
REQ-014 len_err_count  output  CNT_W  packets with wrong word count.

Function
REQ-015 The reference sequence SHALL be 32-bit LFSR: next = {cur[30:0], cur[31]^cur[21]^cur[1]^cur[0]}.
REQ-016 States SHALL be IDLE and RUN only.
REQ-017 IDLE with in_valid: load in_data as the LFSR seed (word not checked), word_cnt=1, go to RUN.
REQ-018 RUN with in_valid: compare in_data to LFSR successor of previous word; mismatch increments word_err_count and sets the packet-fail flag; expected register SHALL advance from the expected value, not the received one; word_cnt increments, saturating at all-ones.
REQ-019 in_done in RUN: packet passes iff word_cnt==EXP_WORDS and no mismatch; otherwise fail; length mismatch increments len_err_count; pkt_count increments; return to IDLE.
REQ-020 in_valid and in_done in the same cycle SHALL process the word first, with its count and compare result included in the verdict.
REQ-021 in_done in IDLE (empty packet) SHALL count as a length error and a bad packet; with simultaneous in_valid, the word counts as a 1-word packet.
REQ-022 pkt_ok/pkt_bad SHALL assert exactly one cycle after in_done is sampled; never both.
REQ-023 All counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-024 clr_stats SHALL zero counters next cycle, take priority over same-cycle increments, and not affect the state machine.
REQ-025 in_valid in RUN beyond EXP_WORDS SHALL still be compared; length error reported at in_done.

Reset
REQ-026 rst SHALL force IDLE, busy=0, pkt_ok=0, pkt_bad=0, all counters 0, word_cnt 0, expected register 0, fail flag 0.
REQ-027 Reset mid-packet SHALL discard the packet without counting it; the next valid word after reset seeds a new packet.

Configuration
REQ-028 Macro PKT_CHECK_FIRST_ERR_EN defined: add outputs first_err_valid (1), first_err_exp (32), first_err_got (32), capturing expected/received of the first mismatch since reset or clr_stats, held until cleared.
REQ-029 Macro undefined: those ports and registers SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package pkt_gen_pkg SHALL hold LFSR width (32), tap indices (31,21,1,0), default seed 32'hACE11234, and the checker state enum.
REQ-031 The combinational LFSR step SHALL be sub-module lfsr32_step (in 32, out 32), reusable by the generator.

Verification
REQ-032 Seed 32'hACE11234 then 30 correct successors, in_done -> pkt_ok one cycle later, pkt_count=1, word_err_count=0, len_err_count=0.
REQ-033 Same packet, word 5 bit 0 flipped -> word_err_count=1, subsequent words pass, pkt_bad, pkt_count=1.
REQ-034 10 correct words then in_done -> len_err_count=1, pkt_bad; in_done alone in IDLE -> len_err_count=2.
REQ-035 rst asserted after word 12 of a packet, then a full good packet -> pkt_count=1, pkt_ok, no errors.
REQ-036 CNT_W=4, 20 bad packets -> pkt_count and len_err_count hold 15; clr_stats coinciding with in_done -> all counters 0.
REQ-037 PKT_CHECK_FIRST_ERR_EN defined, errors at words 3 and 7 -> first_err_exp/got hold word-3 values, first_err_valid=1.

Source files
------------

// File: rtl/pkt_gen_pkg.sv
// rtl/pkt_gen_pkg.sv - shared LFSR constants and checker state type
package pkt_gen_pkg;

  localparam int LFSR_W = 32;
  localparam int TAP_A  = 31;
  localparam int TAP_B  = 21;
  localparam int TAP_C  = 1;
  localparam int TAP_D  = 0;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE11234;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chk_state_e;

endpackage

// File: rtl/lfsr32_step.sv
// rtl/lfsr32_step.sv - one combinational step of the 32-bit Fibonacci LFSR
module lfsr32_step
  import pkt_gen_pkg::*;
(
  input  logic [LFSR_W-1:0] cur_i,
  output logic [LFSR_W-1:0] nxt_o
);

  assign nxt_o = {cur_i[LFSR_W-2:0],
                  cur_i[TAP_A] ^ cur_i[TAP_B] ^ cur_i[TAP_C] ^ cur_i[TAP_D]};

endmodule

// File: rtl/packet_checker.sv
// rtl/packet_checker.sv - LFSR packet checker with saturating statistics
// Optional first-mismatch capture ports under PKT_CHECK_FIRST_ERR_EN.
module packet_checker
  import pkt_gen_pkg::*;
#(
  parameter int EXP_WORDS = 31,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_done,
  input  logic             clr_stats,
  output logic             busy,
  output logic             pkt_ok,
  output logic             pkt_bad,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] word_err_count,
  output logic [CNT_W-1:0] len_err_count
`ifdef PKT_CHECK_FIRST_ERR_EN
  ,
  output logic             first_err_valid,
  output logic [31:0]      first_err_exp,
  output logic [31:0]      first_err_got
`endif
);

  // Wide enough that a count of EXP_WORDS+1 is distinguishable from EXP_WORDS.
  localparam int WC_W = $clog2(EXP_WORDS + 2);
  localparam logic [WC_W-1:0] EXP_CNT = WC_W'(EXP_WORDS);

  chk_state_e        state_q, state_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]       exp_q, exp_d;
  logic              fail_q, fail_d;
  logic              ok_q, ok_d, bad_q, bad_d;
  logic [CNT_W-1:0]  pkt_cnt_q, word_err_q, len_err_q;
  logic              pkt_inc, len_inc, mismatch, len_bad;
  logic [31:0]       lfsr_nxt;

  lfsr32_step u_step (
    .cur_i (exp_q),
    .nxt_o (lfsr_nxt)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    exp_d      = exp_q;
    fail_d     = fail_q;
    ok_d       = 1'b0;
    bad_d      = 1'b0;
    pkt_inc    = 1'b0;
    len_inc    = 1'b0;
    mismatch   = 1'b0;
    len_bad    = 1'b0;
    if (in_valid) begin
      if (state_q == ST_IDLE) begin
        exp_d      = in_data;
        word_cnt_d = WC_W'(1);
        fail_d     = 1'b0;
        state_d    = ST_RUN;
      end else begin
        mismatch   = (in_data != lfsr_nxt);
        exp_d      = lfsr_nxt;
        word_cnt_d = word_cnt_q + WC_W'(~&word_cnt_q);
        fail_d     = fail_q | mismatch;
      end
    end
    // The verdict sees this cycle's word, so it uses the updated count/flag.
    if (in_done) begin
      len_bad    = (word_cnt_d != EXP_CNT) || (word_cnt_d == '0);
      ok_d       = !len_bad && !fail_d;
      bad_d      = !ok_d;
      len_inc    = len_bad;
      pkt_inc    = 1'b1;
      state_d    = ST_IDLE;
      word_cnt_d = '0;
      fail_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      exp_q      <= '0;
      fail_q     <= 1'b0;
      ok_q       <= 1'b0;
      bad_q      <= 1'b0;
      pkt_cnt_q  <= '0;
      word_err_q <= '0;
      len_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      exp_q      <= exp_d;
      fail_q     <= fail_d;
      ok_q       <= ok_d;
      bad_q      <= bad_d;
      if (clr_stats) begin
        pkt_cnt_q  <= '0;
        word_err_q <= '0;
        len_err_q  <= '0;
      end else begin
        pkt_cnt_q  <= pkt_cnt_q  + CNT_W'(pkt_inc  & ~&pkt_cnt_q);
        word_err_q <= word_err_q + CNT_W'(mismatch & ~&word_err_q);
        len_err_q  <= len_err_q  + CNT_W'(len_inc  & ~&len_err_q);
      end
    end
  end

`ifdef PKT_CHECK_FIRST_ERR_EN
  logic        fe_valid_q;
  logic [31:0] fe_exp_q, fe_got_q;

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      fe_valid_q <= 1'b0;
      fe_exp_q   <= '0;
      fe_got_q   <= '0;
    end else if (mismatch && !fe_valid_q) begin
      fe_valid_q <= 1'b1;
      fe_exp_q   <= lfsr_nxt;
      fe_got_q   <= in_data;
    end
  end

  assign first_err_valid = fe_valid_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_got   = fe_got_q;
`endif

  assign busy           = (state_q == ST_RUN);
  assign pkt_ok         = ok_q;
  assign pkt_bad        = bad_q;
  assign pkt_count      = pkt_cnt_q;
  assign word_err_count = word_err_q;
  assign len_err_count  = len_err_q;

endmodule

// File: tb/tb_packet_checker.sv
// tb/tb_packet_checker.sv - directed self-checking bench for packet_checker
module tb_packet_checker;

  localparam logic [31:0] SEED = 32'hACE11234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_done = 1'b0;
  logic        clr_stats = 1'b0;

  logic        busy, pkt_ok, pkt_bad;
  logic [15:0] pkt_count, word_err_count, len_err_count;
  logic        busy4, pkt_ok4, pkt_bad4;
  logic [3:0]  pkt_count4, word_err_count4, len_err_count4;
`ifdef PKT_CHECK_FIRST_ERR_EN
  logic        fe_valid, fe_valid4;
  logic [31:0] fe_exp, fe_got, fe_exp4, fe_got4;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model_w;
  logic [31:0] first_exp, first_got;

  always #5 clk = ~clk;

  packet_checker #(.EXP_WORDS(31), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_done        (in_done),
    .clr_stats      (clr_stats),
    .busy           (busy),
    .pkt_ok         (pkt_ok),
    .pkt_bad        (pkt_bad),
    .pkt_count      (pkt_count),
    .word_err_count (word_err_count),
    .len_err_count  (len_err_count)
`ifdef PKT_CHECK_FIRST_ERR_EN
    ,
    .first_err_valid(fe_valid),
    .first_err_exp  (fe_exp),
    .first_err_got  (fe_got)
`endif
  );

  packet_checker #(.EXP_WORDS(31), .CNT_W(4)) dut4 (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_done        (in_done),
    .clr_stats      (clr_stats),
    .busy           (busy4),
    .pkt_ok         (pkt_ok4),
    .pkt_bad        (pkt_bad4),
    .pkt_count      (pkt_count4),
    .word_err_count (word_err_count4),
    .len_err_count  (len_err_count4)
`ifdef PKT_CHECK_FIRST_ERR_EN
    ,
    .first_err_valid(fe_valid4),
    .first_err_exp  (fe_exp4),
    .first_err_got  (fe_got4)
`endif
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  task automatic drive_cycle(input logic [31:0] d, input logic v, input logic dn, input logic clr);
    in_data   = d;
    in_valid  = v;
    in_done   = dn;
    clr_stats = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_done   = 1'b0;
    clr_stats = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Sends n words of the reference sequence; indices bad_a/bad_b get bit 0 flipped.
  task automatic send_words(input int n, input int bad_a, input int bad_b, input bit cont);
    logic [31:0] w;
    logic [31:0] d;
    bit          have_first = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = (i == 0 && !cont) ? SEED : lfsr_next(model_w);
      model_w = w;
      d = w;
      if (i == bad_a || i == bad_b) begin
        d = w ^ 32'h1;
        if (!have_first) begin
          first_exp  = w;
          first_got  = d;
          have_first = 1'b1;
        end
      end
      drive_cycle(d, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (pkt_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b want 0", pkt_ok); end
    n_cmp++; if (pkt_bad !== 1'b0) begin n_fail++; $display("FAIL reset_bad: got %b want 0", pkt_bad); end
    n_cmp++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_count); end
    n_cmp++; if (word_err_count !== 16'd0) begin n_fail++; $display("FAIL reset_word_err: got %0d want 0", word_err_count); end
    n_cmp++; if (len_err_count !== 16'd0) begin n_fail++; $display("FAIL reset_len_err: got %0d want 0", len_err_count); end
  endtask

  task automatic test_good_packet();
    do_reset();
    send_words(31, -1, -1, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy: got %b want 1", busy); end
    n_cmp++; if (pkt_ok !== 1'b0) begin n_fail++; $display("FAIL good_early_ok: got %b want 0", pkt_ok); end
    drive_cycle('0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pkt_ok !== 1'b1) begin n_fail++; $display("FAIL good_ok: got %b want 1", pkt_ok); end
    n_cmp++; if (pkt_bad !== 1'b0) begin n_fail++; $display("FAIL good_bad: got %b want 0", pkt_bad); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_idle: got %b want 0", busy); end
    n_cmp++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL good_pkt_cnt: got %0d want 1", pkt_count); end
    n_cmp++; if (word_err_count !== 16'd0) begin n_fail++; $display("FAIL good_word_err: got %0d want 0", word_err_count); end
    n_cmp++; if (len_err_count !== 16'd0) begin n_fail++; $display("FAIL good_len_err: got %0d want 0", len_err_count); end
    drive_cycle('0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pkt_ok !== 1'b0) begin n_fail++; $display("FAIL good_ok_pulse: got %b want 0", pkt_ok); end
  endtask

  task automatic test_word_error();
    do_reset();
    send_words(31, 4, -1, 1'b0);
    n_cmp++; if (word_err_count !== 16'd1) begin n_fail++; $display("FAIL werr_count: got %0d want 1", word_err_count); end
    drive_cycle('0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pkt_bad !== 1'b1 || pkt_ok !== 1'b0) begin n_fail++; $display("FAIL werr_verdict: got ok=%b bad=%b want ok=0 bad=1", pkt_ok, pkt_bad); end
    n_cmp++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL werr_pkt_cnt: got %0d want 1", pkt_count); end
    n_cmp++; if (len_err_count !== 16'd0) begin n_fail++; $display("FAIL werr_len_err: got %0d want 0", len_err_count); end
  endtask

  task automatic test_len_error();
    do_reset();
    send_words(10, -1, -1, 1'b0);
    drive_cycle('0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pkt_bad !== 1'b1) begin n_fail++; $display("FAIL short_bad: got %b want 1", pkt_bad); end
    n_cmp++; if (len_err_count !== 16'd1) begin n_fail++; $display("FAIL short_len_err: got %0d want 1", len_err_count); end
    drive_cycle('0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pkt_bad !== 1'b1) begin n_fail++; $display("FAIL empty_bad: got %b want 1", pkt_bad); end
    n_cmp++; if (len_err_count !== 16'd2) begin n_fail++; $display("FAIL empty_len_err: got %0d want 2", len_err_count); end
    n_cmp++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL empty_pkt_cnt: got %0d want 2", pkt_count); end
  endtask

  task automatic test_done_with_word();
    do_reset();
    send_words(30, -1, -1, 1'b0);
    drive_cycle(lfsr_next(model_w), 1'b1, 1'b1, 1'b0);
    n_cmp++; if (pkt_ok !== 1'b1) begin n_fail++; $display("FAIL lastword_ok: got %b want 1", pkt_ok); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lastword_idle: got %b want 0", busy); end
    drive_cycle(32'h1234_5678, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (pkt_bad !== 1'b1) begin n_fail++; $display("FAIL oneword_bad: got %b want 1", pkt_bad); end
    n_cmp++; if (len_err_count !== 16'd1) begin n_fail++; $display("FAIL oneword_len_err: got %0d want 1", len_err_count); end
    n_cmp++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL oneword_pkt_cnt: got %0d want 2", pkt_count); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL oneword_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    send_words(12, -1, -1, 1'b0);
    do_reset();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    send_words(31, -1, -1, 1'b0);
    drive_cycle('0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pkt_ok !== 1'b1) begin n_fail++; $display("FAIL midrst_ok: got %b want 1", pkt_ok); end
    n_cmp++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL midrst_pkt_cnt: got %0d want 1", pkt_count); end
    n_cmp++; if (word_err_count !== 16'd0 || len_err_count !== 16'd0) begin n_fail++; $display("FAIL midrst_errs: got w=%0d l=%0d want 0 0", word_err_count, len_err_count); end
  endtask

  task automatic test_overlength();
    do_reset();
    send_words(33, 32, -1, 1'b0);
    drive_cycle('0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (word_err_count !== 16'd1) begin n_fail++; $display("FAIL over_word_err: got %0d want 1", word_err_count); end
    n_cmp++; if (len_err_count !== 16'd1) begin n_fail++; $display("FAIL over_len_err: got %0d want 1", len_err_count); end
    n_cmp++; if (pkt_bad !== 1'b1) begin n_fail++; $display("FAIL over_bad: got %b want 1", pkt_bad); end
  endtask

  task automatic test_clr_mid_packet();
    do_reset();
    drive_cycle('0, 1'b0, 1'b1, 1'b0);
    send_words(15, -1, -1, 1'b0);
    drive_cycle('0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (pkt_count !== 16'd0 || len_err_count !== 16'd0) begin n_fail++; $display("FAIL clr_counts: got p=%0d l=%0d want 0 0", pkt_count, len_err_count); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy: got %b want 1", busy); end
    send_words(16, -1, -1, 1'b1);
    drive_cycle('0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pkt_ok !== 1'b1) begin n_fail++; $display("FAIL clr_ok: got %b want 1", pkt_ok); end
    n_cmp++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL clr_pkt_cnt: got %0d want 1", pkt_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) drive_cycle('0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pkt_count4 !== 4'd15) begin n_fail++; $display("FAIL sat_pkt_cnt4: got %0d want 15", pkt_count4); end
    n_cmp++; if (len_err_count4 !== 4'd15) begin n_fail++; $display("FAIL sat_len_err4: got %0d want 15", len_err_count4); end
    n_cmp++; if (pkt_count !== 16'd20) begin n_fail++; $display("FAIL sat_pkt_cnt16: got %0d want 20", pkt_count); end
    drive_cycle('0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (pkt_count4 !== 4'd0 || len_err_count4 !== 4'd0 || word_err_count4 !== 4'd0) begin n_fail++; $display("FAIL sat_clr4: got p=%0d l=%0d w=%0d want 0 0 0", pkt_count4, len_err_count4, word_err_count4); end
    n_cmp++; if (pkt_count !== 16'd0 || len_err_count !== 16'd0) begin n_fail++; $display("FAIL sat_clr16: got p=%0d l=%0d want 0 0", pkt_count, len_err_count); end
    n_cmp++; if (pkt_bad !== 1'b1) begin n_fail++; $display("FAIL sat_clr_bad: got %b want 1", pkt_bad); end
  endtask

`ifdef PKT_CHECK_FIRST_ERR_EN
  task automatic test_first_err();
    do_reset();
    n_cmp++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL fe_reset: got %b want 0", fe_valid); end
    send_words(31, 2, 6, 1'b0);
    n_cmp++; if (fe_valid !== 1'b1) begin n_fail++; $display("FAIL fe_valid: got %b want 1", fe_valid); end
    n_cmp++; if (fe_exp !== first_exp) begin n_fail++; $display("FAIL fe_exp: got %h want %h", fe_exp, first_exp); end
    n_cmp++; if (fe_got !== first_got) begin n_fail++; $display("FAIL fe_got: got %h want %h", fe_got, first_got); end
    n_cmp++; if (word_err_count !== 16'd2) begin n_fail++; $display("FAIL fe_word_err: got %0d want 2", word_err_count); end
    drive_cycle('0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL fe_clr: got %b want 0", fe_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_packet();
    test_word_error();
    test_len_error();
    test_done_with_word();
    test_reset_mid_packet();
    test_overlength();
    test_clr_mid_packet();
    test_saturation();
`ifdef PKT_CHECK_FIRST_ERR_EN
    test_first_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
